// File: rtl/mask_deserializer.sv
// Reassembles a wide mask row from narrow interleaved beats. Bit i of each beat belongs to lane i.
// A beat k lands at row bit i*step+k, where step depends on the latched resolution.
module mask_deserializer #(
    parameter int IP_CHANNEL_WIDTH = 20,
    parameter int OP_CHANNEL_WIDTH = 1080,
    parameter int stepSel0         = 16,
    parameter int stepSel1         = 32,
    parameter int stepSel2         = 54
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
    input  logic                        valid_in,
    output logic                        in_ready,
    input  logic [1:0]                  imageResolution,
    input  logic                        flush,
    output logic [OP_CHANNEL_WIDTH-1:0] DOUT,
    output logic                        row_valid,
    input  logic                        row_ready
);

    localparam int CNT_W = $clog2(stepSel2);
    localparam int IDX_W = $clog2(OP_CHANNEL_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [1:0]                  res_r;
    logic [OP_CHANNEL_WIDTH-1:0] dout_r;
    logic                        row_valid_r;

    logic [1:0]                  res_s;
    logic [CNT_W:0]              step_s;
    logic                        last_s;
    logic [OP_CHANNEL_WIDTH-1:0] dout_next_s;

    function automatic logic [1:0] res_map(input logic [1:0] r);
        return (r == 2'b11) ? 2'b10 : r;
    endfunction

    function automatic logic [CNT_W:0] step_of(input logic [1:0] r);
        case (r)
            2'b00:   step_of = (CNT_W+1)'(stepSel0);
            2'b01:   step_of = (CNT_W+1)'(stepSel1);
            default: step_of = (CNT_W+1)'(stepSel2);
        endcase
    endfunction

    // Next-row image: the first beat of a row uses the live resolution and starts from a cleared row.
    always_comb begin
        res_s       = (state_r == IDLE) ? res_map(imageResolution) : res_r;
        step_s      = step_of(res_s);
        last_s      = ({1'b0, cnt_r} == (step_s - (CNT_W+1)'(1)));
        dout_next_s = (state_r == IDLE) ? '0 : dout_r;
        for (int i = 0; i < IP_CHANNEL_WIDTH; i++) begin
            dout_next_s[IDX_W'(i * int'(step_s) + int'(cnt_r))] = DIN[i];
        end
    end

    // Row assembly FSM; flush outranks beats and the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            res_r       <= 2'b00;
            dout_r      <= '0;
            row_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            row_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, COLLECT: begin
                    if (valid_in) begin
                        if (state_r == IDLE) begin
                            res_r <= res_s;
                        end
                        dout_r <= dout_next_s;
                        if (last_s) begin
                            state_r     <= FULL;
                            cnt_r       <= '0;
                            row_valid_r <= 1'b1;
                        end else begin
                            state_r <= COLLECT;
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (row_ready) begin
                        state_r     <= IDLE;
                        row_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    row_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r != FULL);
    assign DOUT      = dout_r;
    assign row_valid = row_valid_r;

endmodule

// File: tb/tb_mask_deserializer.sv
// Scoreboard bench for mask_deserializer: stimulus pushes expected rows with their completion cycle,
// a negedge monitor pops and compares whenever row_valid rises.
module tb_mask_deserializer;

    localparam int IPW = 20;
    localparam int OPW = 1080;

    logic            clk = 1'b0;
    logic            rst;
    logic [IPW-1:0]  DIN;
    logic            valid_in;
    logic            in_ready;
    logic [1:0]      imageResolution;
    logic            flush;
    logic [OPW-1:0]  DOUT;
    logic            row_valid;
    logic            row_ready;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_rv = 1'b0;

    typedef struct {
        logic [OPW-1:0] row;
        int             cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    mask_deserializer dut (
        .clk             (clk),
        .rst             (rst),
        .DIN             (DIN),
        .valid_in        (valid_in),
        .in_ready        (in_ready),
        .imageResolution (imageResolution),
        .flush           (flush),
        .DOUT            (DOUT),
        .row_valid       (row_valid),
        .row_ready       (row_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OPW-1:0] make_src(input int unsigned seed, input int step);
        logic [OPW-1:0] r = '0;
        int unsigned    x = seed;
        for (int j = 0; j < IPW * step; j++) begin
            x ^= x << 13;
            x ^= x >> 17;
            x ^= x << 5;
            r[j] = x[0];
        end
        return r;
    endfunction

    function automatic logic [IPW-1:0] beat_of(input logic [OPW-1:0] src, input int step, input int k);
        logic [IPW-1:0] b;
        for (int i = 0; i < IPW; i++) b[i] = src[i * step + k];
        return b;
    endfunction

    task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        int first;
        total++;
        if (act !== exp) begin
            bad++;
            first = 0;
            for (int j = OPW - 1; j >= 0; j--) if (act[j] !== exp[j]) first = j;
            $display("FAIL %s: first differing bit %0d got %b want %b", name, first, act[first], exp[first]);
        end
    endtask

    // Monitor: each new row presentation is matched against the oldest expected row.
    always @(negedge clk) begin
        if (row_valid && !prev_rv) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row: row_valid rose at cycle %0d, want no row", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check_row("row_data", DOUT, mon_e.row);
                check_bits("row_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        prev_rv <= row_valid;
    end

    task automatic drive_beat(input logic [IPW-1:0] d, output int acc);
        int budget = 0;
        DIN      = d;
        valid_in = 1'b1;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready got 0 want 1 within 50 cycles");
        end
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic send_row(input logic [OPW-1:0] src, input int step, input logic [1:0] res,
                            input bit gaps, input int change_at);
        int   c = 0;
        exp_t e;
        imageResolution = res;
        for (int k = 0; k < step; k++) begin
            if (k == change_at) imageResolution = 2'b10;
            drive_beat(beat_of(src, step, k), c);
            if (gaps && (k % 3 == 1) && (k != step - 1)) begin
                valid_in = 1'b0;
                repeat (1 + k % 4) @(posedge clk);
                #1;
            end
        end
        valid_in = 1'b0;
        e.row = src;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OPW-1:0] src_a, src_b, src_b3, src_c, src_d, src_e, src_f, src_g, src_h, src_i, partial;
        int             c;

        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; row_ready = 1'b1;
        DIN = '0; imageResolution = 2'b00;
        repeat (2) @(negedge clk);
        check_bits("rst_row_valid", 64'(row_valid), 64'd0);
        check_row("rst_dout", DOUT, '0);
        check_bits("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_bits("rel_in_ready", 64'(in_ready), 64'd1);

        // Res 01, back-to-back, one-cycle row_valid pulse
        src_a = make_src(32'h1234_5678, 32);
        send_row(src_a, 32, 2'b01, 1'b0, -1);
        check_bits("r029_rv_high", 64'(row_valid), 64'd1);
        @(posedge clk); #1;
        check_bits("r029_rv_pulse", 64'(row_valid), 64'd0);
        check_row("r029_dout_kept", DOUT, src_a);
        check_bits("r029_in_ready", 64'(in_ready), 64'd1);

        // Res 10 with gaps, then res 11 treated as 10
        src_b = make_src(32'h0BAD_F00D, 54);
        send_row(src_b, 54, 2'b10, 1'b1, -1);
        @(posedge clk); #1;
        src_b3 = make_src(32'h5EED_0003, 54);
        send_row(src_b3, 54, 2'b11, 1'b0, -1);
        @(posedge clk); #1;

        // Res 00, downstream stalls while upstream keeps offering a beat
        row_ready = 1'b0;
        src_c = make_src(32'hCAFE_0001, 16);
        src_d = make_src(32'hBEEF_0002, 16);
        send_row(src_c, 16, 2'b00, 1'b0, -1);
        DIN = beat_of(src_d, 16, 0);
        valid_in = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check_bits("r031_in_ready", 64'(in_ready), 64'd0);
            check_bits("r031_row_valid", 64'(row_valid), 64'd1);
            check_row("r031_dout_stable", DOUT, src_c);
        end
        row_ready = 1'b1;
        send_row(src_d, 16, 2'b00, 1'b0, -1);
        @(posedge clk); #1;

        // Resolution change mid-row is ignored
        src_e = make_src(32'h7777_1234, 32);
        send_row(src_e, 32, 2'b01, 1'b0, 5);
        imageResolution = 2'b01;
        @(posedge clk); #1;

        // Flush at beat 20 together with a valid beat
        src_f = make_src(32'h0F0F_5A5A, 32);
        imageResolution = 2'b01;
        for (int k = 0; k < 20; k++) drive_beat(beat_of(src_f, 32, k), c);
        DIN = beat_of(src_f, 32, 20);
        valid_in = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        valid_in = 1'b0;
        check_bits("r033_in_ready", 64'(in_ready), 64'd1);
        check_bits("r033_row_valid", 64'(row_valid), 64'd0);
        partial = '0;
        for (int i = 0; i < IPW; i++)
            for (int k = 0; k < 20; k++) partial[i * 32 + k] = src_f[i * 32 + k];
        check_row("r033_dout_kept", DOUT, partial);
        repeat (3) @(posedge clk);
        #1;
        check_bits("r033_no_row", 64'(row_valid), 64'd0);
        src_g = make_src(32'h1357_9BDF, 32);
        send_row(src_g, 32, 2'b01, 1'b0, -1);
        @(posedge clk); #1;

        // Async reset mid-row
        src_h = make_src(32'h2468_ACE0, 54);
        imageResolution = 2'b10;
        for (int k = 0; k < 10; k++) drive_beat(beat_of(src_h, 54, k), c);
        valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_bits("r034a_row_valid", 64'(row_valid), 64'd0);
        check_row("r034a_dout", DOUT, '0);
        check_bits("r034a_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_bits("r034a_rel_in_ready", 64'(in_ready), 64'd1);

        // Async reset while holding a full row
        row_ready = 1'b0;
        src_i = make_src(32'h9999_0101, 16);
        send_row(src_i, 16, 2'b00, 1'b0, -1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_bits("r034b_row_valid", 64'(row_valid), 64'd0);
        check_row("r034b_dout", DOUT, '0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_bits("r034b_in_ready", 64'(in_ready), 64'd1);
        check_bits("r034b_row_valid_after", 64'(row_valid), 64'd0);
        row_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bits("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mask_deserializer.md
MASK_DESERIALIZER -- requirements
Module: mask_deserializer

Interface
REQ-001 Parameter IP_CHANNEL_WIDTH, default 20, SHALL be the width of the narrow input word (one bit per interleave lane).
REQ-002 Parameter OP_CHANNEL_WIDTH, default 1080, SHALL be the width of the reassembled row.
REQ-003 Parameters stepSel0/stepSel1/stepSel2, defaults 16/32/54, SHALL be the beats per row for imageResolution 00/01/10.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-high reset, rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 DIN  input  IP_CHANNEL_WIDTH  one interleaved beat; bit i belongs to lane i.
REQ-008 valid_in  input  1  DIN carries a beat this cycle.
REQ-009 in_ready  output  1  the block accepts a beat this cycle.
REQ-010 imageResolution  input  2  row format select, sampled at row start only.
REQ-011 flush  input  1  synchronous abort: drop any partial or held row.
REQ-012 DOUT  output  OP_CHANNEL_WIDTH  reassembled row, registered.
REQ-013 row_valid  output  1  DOUT holds a complete row.
REQ-014 row_ready  input  1  downstream consumes DOUT when row_valid is also high.

Function
REQ-015 The block SHALL implement states IDLE, COLLECT and FULL, with a beat counter cnt of width clog2(stepSel2).
REQ-016 A beat SHALL be accepted when valid_in && in_ready; in_ready SHALL be 1 in IDLE and COLLECT and 0 in FULL (combinational from state).
REQ-017 On an accepted beat in IDLE, the block SHALL latch imageResolution into res_q (11 treated as 10), clear DOUT to 0, write the beat at cnt=0, set cnt=1, and go to COLLECT.
REQ-018 Each accepted beat k SHALL write DOUT[i*step+k] = DIN[i] for i = 0..IP_CHANNEL_WIDTH-1, where step = stepSel[res_q].
REQ-019 On an accepted beat with cnt == step-1, the block SHALL go to FULL, assert row_valid on the next cycle, and reset cnt to 0.
REQ-020 Cycles in COLLECT without valid_in SHALL hold cnt and DOUT (gaps allowed).
REQ-021 Bits of DOUT at or above IP_CHANNEL_WIDTH*step SHALL read 0 for step < stepSel2.
REQ-022 In FULL, DOUT and row_valid SHALL be stable until row_ready is 1; valid_in SHALL be ignored.
REQ-023 On row_valid && row_ready, the block SHALL go to IDLE and deassert row_valid on the next cycle; DOUT SHALL keep its last value until the next row starts.
REQ-024 Changes to imageResolution after row start SHALL have no effect until the next IDLE->COLLECT transition.
REQ-025 flush SHALL force IDLE, cnt=0 and row_valid=0 on the next edge, and SHALL take priority over a simultaneous accepted beat or row handshake; DOUT is not cleared by flush.
REQ-026 Latency SHALL be exactly one cycle from acceptance of the last beat to row_valid=1; minimum row period is step+1 cycles with row_ready held high.

Reset
REQ-027 While rst=1 and on its release, state SHALL be IDLE, cnt=0, res_q=00, DOUT=0, row_valid=0, in_ready=1.
REQ-028 rst asserted mid-row or in FULL SHALL discard the row immediately, without waiting for a clock edge.

Verification
REQ-029 Res 01, send 32 beats of a 640-bit row-interleaved pattern back-to-back, row_ready=1 -> row_valid pulses for 1 cycle one cycle after beat 31; DOUT[639:0] matches the source; DOUT[1079:640]=0.
REQ-030 Res 10, 54 beats with random valid_in gaps -> DOUT equals the 1080-bit source; row_valid rises exactly one cycle after the 54th accepted beat.
REQ-031 Res 00, hold row_ready=0 for 10 cycles after completion while driving valid_in=1 -> in_ready=0, DOUT unchanged, no beats lost; release -> next row starts in IDLE and is accepted.
REQ-032 Res 01 latched, switch imageResolution to 10 at beat 5 -> row still completes after 32 beats with the 01 mapping.
REQ-033 flush asserted with valid_in at beat 20 of 32 -> state is IDLE next cycle, row_valid never rises, and a following full row reassembles correctly.
REQ-034 Assert rst asynchronously at beat 10 and in FULL -> row_valid=0 and DOUT=0 before the next clk edge; in_ready=1 after release.
